spram_bridge: RTL and testbench

- Initiator/controller that drives one 16-bit SPRAM macro (16K x 16, 1-cycle synchronous read, 4-bit nibble write mask) from a 32-bit valid/ready request port.
- Each 32-bit access is split into two sequential 16-bit SPRAM accesses, low half first.
- Byte strobes are translated to nibble masks, and the two read halves are reassembled into one registered 32-bit response.
- Sits between the SoC bus fabric and the SPRAM wrapper; it is the only master of that SPRAM.

---
 rtl/spram_bridge.sv | 106 ++++++++++
 tb/tb_spram_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spram_bridge.sv
// 32-bit valid/ready request port to a 16K x 16 SPRAM macro.
// Each word access runs as two halfword accesses, low half first, with a registered 32-bit response.
module spram_bridge #(
  parameter bit RESP_ON_WRITE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [12:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [13:0] sram_addr,
  output logic        sram_write_enable,
  output logic [3:0]  sram_write_mask,
  output logic [15:0] sram_data_inp,
  input  logic [15:0] sram_data_out
);

  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

  state_t      state, state_next;
  logic [12:0] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [15:0] lo_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = LO;
      LO:      state_next = HI;
      HI:      state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SRAM strobes are gated by reset so an abort in HI cannot commit the high half.
  always_comb begin
    req_ready         = (state == IDLE);
    sram_addr         = '0;
    sram_write_enable = 1'b0;
    sram_write_mask   = '0;
    sram_data_inp     = '0;
    if (!reset) begin
      case (state)
        LO: begin
          sram_addr         = {addr_q, 1'b0};
          sram_data_inp     = wdata_q[15:0];
          sram_write_mask   = {wstrb_q[1], wstrb_q[1], wstrb_q[0], wstrb_q[0]};
          sram_write_enable = write_q;
        end
        HI: begin
          sram_addr         = {addr_q, 1'b1};
          sram_data_inp     = wdata_q[31:16];
          sram_write_mask   = {wstrb_q[3], wstrb_q[3], wstrb_q[2], wstrb_q[2]};
          sram_write_enable = write_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      lo_q       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
          end
        end
        HI: lo_q <= sram_data_out;
        FIN: begin
          if (!write_q || RESP_ON_WRITE) begin
            resp_valid <= 1'b1;
            resp_rdata <= write_q ? 32'h0 : {sram_data_out, lo_q};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_bridge.sv
// Directed bench for spram_bridge: two instances (write ack on / off), each backed by a
// behavioural 16K x 16 SPRAM with nibble mask and 1-cycle read latency.
module tb_spram_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [12:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;

  logic        a_ready, a_rv, a_we;
  logic [31:0] a_rdata;
  logic [13:0] a_addr;
  logic [3:0]  a_mask;
  logic [15:0] a_din, a_dout;

  logic        b_ready, b_rv, b_we;
  logic [31:0] b_rdata;
  logic [13:0] b_addr;
  logic [3:0]  b_mask;
  logic [15:0] b_din, b_dout;

  logic [15:0] mem_a [16384];
  logic [15:0] mem_b [16384];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  spram_bridge #(.RESP_ON_WRITE(1'b1)) dut_a (
    .clock(clock), .reset(reset),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(a_rv), .resp_rdata(a_rdata),
    .sram_addr(a_addr), .sram_write_enable(a_we), .sram_write_mask(a_mask),
    .sram_data_inp(a_din), .sram_data_out(a_dout)
  );

  spram_bridge #(.RESP_ON_WRITE(1'b0)) dut_b (
    .clock(clock), .reset(reset),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(b_rv), .resp_rdata(b_rdata),
    .sram_addr(b_addr), .sram_write_enable(b_we), .sram_write_mask(b_mask),
    .sram_data_inp(b_din), .sram_data_out(b_dout)
  );

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
  end

  // SPRAM models: read-before-write, mask bit n enables nibble n
  always @(posedge clock) begin
    a_dout <= mem_a[a_addr];
    b_dout <= mem_b[b_addr];
    if (a_we)
      for (int n = 0; n < 4; n++)
        if (a_mask[n]) mem_a[a_addr][n*4 +: 4] <= a_din[n*4 +: 4];
    if (b_we)
      for (int n = 0; n < 4; n++)
        if (b_mask[n]) mem_b[b_addr][n*4 +: 4] <= b_din[n*4 +: 4];
  end

  logic        use_b = 1'b0;
  logic        o_ready, o_rv, o_we;
  logic [31:0] o_rdata;
  logic [13:0] o_addr;
  logic [3:0]  o_mask;
  logic [15:0] o_din;

  always_comb begin
    o_ready = use_b ? b_ready : a_ready;
    o_rv    = use_b ? b_rv    : a_rv;
    o_we    = use_b ? b_we    : a_we;
    o_rdata = use_b ? b_rdata : a_rdata;
    o_addr  = use_b ? b_addr  : a_addr;
    o_mask  = use_b ? b_mask  : a_mask;
    o_din   = use_b ? b_din   : a_din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          on_b;
    bit          wr;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  lo_mask;
    logic [3:0]  hi_mask;
    logic [13:0] lo_addr;
    bit          exp_valid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic run_vec(input vec_t v);
    use_b = v.on_b;
    @(negedge clock);
    req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
    if (v.on_b) b_valid = 1'b1; else a_valid = 1'b1;
    chk("ready_idle", 32'(o_ready), 32'd1);
    @(negedge clock);
    a_valid = 1'b0; b_valid = 1'b0;
    chk("lo_ready", 32'(o_ready), 32'd0);
    chk("lo_addr", 32'(o_addr), 32'(v.lo_addr));
    chk("lo_we", 32'(o_we), 32'(v.wr));
    chk("lo_mask", 32'(o_mask), 32'(v.lo_mask));
    if (v.wr) chk("lo_data", 32'(o_din), 32'(v.wdata[15:0]));
    @(negedge clock);
    chk("hi_addr", 32'(o_addr), 32'(v.lo_addr) + 32'd1);
    chk("hi_we", 32'(o_we), 32'(v.wr));
    chk("hi_mask", 32'(o_mask), 32'(v.hi_mask));
    if (v.wr) chk("hi_data", 32'(o_din), 32'(v.wdata[31:16]));
    @(negedge clock);
    chk("fin_we", 32'(o_we), 32'd0);
    chk("fin_addr", 32'(o_addr), 32'd0);
    chk("fin_rv", 32'(o_rv), 32'd0);
    @(negedge clock);
    chk("resp_valid", 32'(o_rv), 32'(v.exp_valid));
    if (v.exp_valid) chk("resp_rdata", o_rdata, v.exp_rdata);
  endtask

  initial begin
    //         on_b wr  addr      wdata         wstrb    lo_m     hi_m     lo_addr     ev  exp_rdata
    vecs[0]  = '{0, 1, 13'd5,    32'hDEADBEEF, 4'hF,    4'hF,    4'hF,    14'd10,    1, 32'h0};
    vecs[1]  = '{0, 0, 13'd5,    32'h0,        4'h0,    4'h0,    4'h0,    14'd10,    1, 32'hDEADBEEF};
    vecs[2]  = '{0, 1, 13'd8191, 32'hCAFEF00D, 4'hF,    4'hF,    4'hF,    14'd16382, 1, 32'h0};
    vecs[3]  = '{0, 0, 13'd8191, 32'h0,        4'h0,    4'h0,    4'h0,    14'd16382, 1, 32'hCAFEF00D};
    vecs[4]  = '{0, 0, 13'd8190, 32'h0,        4'h0,    4'h0,    4'h0,    14'd16380, 1, 32'h0};
    vecs[5]  = '{0, 1, 13'd5,    32'h00AA0000, 4'b0100, 4'b0000, 4'b0011, 14'd10,    1, 32'h0};
    vecs[6]  = '{0, 0, 13'd5,    32'h0,        4'h0,    4'h0,    4'h0,    14'd10,    1, 32'hDEAABEEF};
    vecs[7]  = '{0, 1, 13'd5,    32'hFFFFFFFF, 4'h0,    4'h0,    4'h0,    14'd10,    1, 32'h0};
    vecs[8]  = '{0, 0, 13'd5,    32'h0,        4'h0,    4'h0,    4'h0,    14'd10,    1, 32'hDEAABEEF};
    vecs[9]  = '{0, 1, 13'd7,    32'h11112222, 4'hF,    4'hF,    4'hF,    14'd14,    1, 32'h0};
    vecs[10] = '{0, 0, 13'd7,    32'h0,        4'h0,    4'h0,    4'h0,    14'd14,    1, 32'h11112222};
    vecs[11] = '{1, 1, 13'd3,    32'h12345678, 4'hF,    4'hF,    4'hF,    14'd6,     0, 32'h0};
    vecs[12] = '{1, 0, 13'd3,    32'h0,        4'h0,    4'h0,    4'h0,    14'd6,     1, 32'h12345678};
    vecs[13] = '{1, 1, 13'd3,    32'h0000FF00, 4'b0010, 4'b1100, 4'b0000, 14'd6,     0, 32'h0};

    repeat (2) @(negedge clock);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_rv", 32'(a_rv), 32'd0);
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_we", 32'(a_we), 32'd0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_b_rv", 32'(b_rv), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // B: acked-less write then readback proves the masked write landed
    run_vec('{1, 0, 13'd3, 32'h0, 4'h0, 4'h0, 4'h0, 14'd6, 1, 32'h1234FF78});

    // Back-to-back reads with req_valid held high
    use_b = 1'b0;
    @(negedge clock);
    req_write = 1'b0; req_addr = 13'd5; req_wstrb = 4'h0; a_valid = 1'b1;
    chk("b2b_ready_T", 32'(a_ready), 32'd1);
    @(negedge clock);
    req_addr = 13'd7;
    for (int k = 1; k <= 3; k++) begin
      chk("b2b_ready_busy", 32'(a_ready), 32'd0);
      chk("b2b_rv_busy", 32'(a_rv), 32'd0);
      @(negedge clock);
    end
    chk("b2b_rv1", 32'(a_rv), 32'd1);
    chk("b2b_rdata1", a_rdata, 32'hDEAABEEF);
    chk("b2b_ready_T4", 32'(a_ready), 32'd1);
    @(negedge clock);
    a_valid = 1'b0;
    for (int k = 5; k <= 7; k++) begin
      chk("b2b_rv_gap", 32'(a_rv), 32'd0);
      chk("b2b_rdata_hold", a_rdata, 32'hDEAABEEF);
      @(negedge clock);
    end
    chk("b2b_rv2", 32'(a_rv), 32'd1);
    chk("b2b_rdata2", a_rdata, 32'h11112222);
    @(negedge clock);
    chk("b2b_rv_after", 32'(a_rv), 32'd0);

    // Reset during HI of a write to word 7
    req_write = 1'b1; req_addr = 13'd7; req_wdata = 32'hAAAABBBB; req_wstrb = 4'hF; a_valid = 1'b1;
    @(negedge clock);
    a_valid = 1'b0;
    chk("abort_lo_we", 32'(a_we), 32'd1);
    @(negedge clock);
    chk("abort_hi_addr", 32'(a_addr), 32'd15);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_ready", 32'(a_ready), 32'd1);
    chk("abort_we", 32'(a_we), 32'd0);
    chk("abort_rdata", a_rdata, 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("abort_no_rv", 32'(a_rv), 32'd0);
      @(negedge clock);
    end
    run_vec('{0, 0, 13'd7, 32'h0, 4'h0, 4'h0, 4'h0, 14'd14, 1, 32'h1111BBBB});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
